// File: rtl/minimax_host_pkg.sv
// rtl/minimax_host_pkg.sv - shared constants, console entry type and byte-mask helper for minimax_host_if
package minimax_host_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'hfffffff8;
  localparam logic [31:0] EXIT_ADDR_DEF    = 32'hfffffffc;
  localparam logic [31:0] STATUS_ADDR_DEF  = 32'hfffffff4;

  localparam int HALT_BIT    = 31;
  localparam int TIMEOUT_BIT = 30;
  localparam int OVF_BIT     = 29;
  localparam int COUNT_LSB   = 0;
  localparam int COUNT_W     = 16;

`ifdef MINIMAX_HOST_TSTAMP_EN
  // Wide enough for any supported TICK_BITS; the top truncates on output.
  localparam int TSTAMP_W = 64;
`endif

  typedef struct packed {
    logic [3:0]          mask;
    logic [31:0]         data;
`ifdef MINIMAX_HOST_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
  } con_entry_t;

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/minimax_host_fifo.sv
// rtl/minimax_host_fifo.sv - parametrised synchronous first-word-fall-through FIFO
module minimax_host_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/minimax_host_if.sv
// rtl/minimax_host_if.sv - memory-mapped console FIFO, exit register, watchdog and status for the minimax data bus
// Optional MINIMAX_HOST_TSTAMP_EN adds a per-entry tick timestamp and the con_tstamp port.
module minimax_host_if
  import minimax_host_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] EXIT_ADDR    = EXIT_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF,
  parameter int unsigned MAXTICKS     = 100000,
  parameter int          TICK_BITS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rreq,
  output logic [31:0] rdata,
  output logic        rdata_sel,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [31:0] con_data,
  output logic [3:0]  con_mask,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        timeout,
  output logic        overflow
`ifdef MINIMAX_HOST_TSTAMP_EN
  ,
  output logic [TICK_BITS-1:0] con_tstamp
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(MAXTICKS - 1);
  localparam logic [TICK_BITS-1:0] TICK_ONE  = TICK_BITS'(1);

  logic                 frozen, wr_en, con_wr, exit_wr, stat_wr, stat_rd, pop;
  logic                 full, empty;
  logic [AW:0]          count;
  logic [31:0]          wdata_m, status;
  logic [TICK_BITS-1:0] ticks;
  con_entry_t           push_entry, head_entry;

  assign frozen  = halted | timeout;
  assign wr_en   = (wmask != 4'h0) & ~frozen;
  assign con_wr  = wr_en & (addr == CONSOLE_ADDR);
  assign exit_wr = wr_en & (addr == EXIT_ADDR);
  assign stat_wr = wr_en & (addr == STATUS_ADDR);
  assign stat_rd = rreq & (addr == STATUS_ADDR);
  assign wdata_m = mask_bytes(wdata, wmask);

  always_comb begin
    push_entry      = '0;
    push_entry.mask = wmask;
    push_entry.data = wdata_m;
`ifdef MINIMAX_HOST_TSTAMP_EN
    push_entry.tstamp = TSTAMP_W'(ticks);
`endif
  end

  minimax_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(con_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (con_wr),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Head is gated so nothing stale from the storage array is ever presented.
  assign con_valid = ~empty;
  assign pop       = con_valid & con_ready;
  assign con_data  = con_valid ? head_entry.data : 32'h0;
  assign con_mask  = con_valid ? head_entry.mask : 4'h0;
`ifdef MINIMAX_HOST_TSTAMP_EN
  assign con_tstamp = con_valid ? head_entry.tstamp[TICK_BITS-1:0] : '0;
`endif

  always_comb begin
    status                           = '0;
    status[HALT_BIT]                 = halted;
    status[TIMEOUT_BIT]              = timeout;
    status[OVF_BIT]                  = overflow;
    status[COUNT_LSB +: COUNT_W]     = COUNT_W'(count);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata     <= '0;
      rdata_sel <= 1'b0;
      halted    <= 1'b0;
      exit_code <= '0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
      ticks     <= '0;
    end else begin
      rdata_sel <= stat_rd;
      rdata     <= stat_rd ? status : 32'h0;

      if (exit_wr) begin
        halted    <= 1'b1;
        exit_code <= wdata_m;
      end

      // Set and clear are mutually exclusive on a single bus, so priority is moot.
      if (con_wr & full & ~pop) begin
        overflow <= 1'b1;
      end else if (stat_wr & wmask[3] & wdata[OVF_BIT]) begin
        overflow <= 1'b0;
      end

      if (!frozen && ticks != '1) begin
        ticks <= ticks + TICK_ONE;
      end
      if (MAXTICKS != 0 && ticks == TICK_LAST) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/minimax_host_if.md
Name: minimax_host_if

Overview:
- Synthesizable memory-mapped host interface for the minimax core's data bus (addr/wdata/wmask/rreq/rdata).
- Replaces ad-hoc simulation peripherals with real hardware:
  - a console FIFO drained by a host over valid/ready,
  - an exit/halt register,
  - a watchdog tick counter,
  - a readable status register.
- Sits beside data RAM; an external mux selects rdata using rdata_sel.

Parameters:
- FIFO_DEPTH, 16, console FIFO entries; power of two, >= 2.
- CONSOLE_ADDR, 32'hfffffff8, write pushes console entry.
- EXIT_ADDR, 32'hfffffffc, write latches exit code and halts.
- STATUS_ADDR, 32'hfffffff4, read status; write-1-to-clear overflow.
- MAXTICKS, 100000, watchdog limit in cycles; 0 disables watchdog.
- TICK_BITS, 32, tick counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  32  core data address
- wdata  in  32  core write data
- wmask  in  4  byte write enables; nonzero = write
- rreq  in  1  core read request
- rdata  out  32  registered read data
- rdata_sel  out  1  rdata is from this block this cycle
- con_valid  out  1  FIFO head valid
- con_ready  in  1  host accepts head
- con_data  out  32  head data (masked bytes zeroed)
- con_mask  out  4  head byte mask
- halted  out  1  exit register written
- exit_code  out  32  latched exit value
- timeout  out  1  watchdog expired, sticky
- overflow  out  1  console push dropped while full, sticky

Behaviour:
- Reset (reset low, async): FIFO empty, all outputs 0, ticks = 0. Release is synchronous to clk.
- Core writes are accepted when wmask != 0, addr matches, and the block is not frozen. Frozen = halted | timeout.
- Console write:
  - Pushes {wmask, wdata with unmasked bytes forced to 0}.
  - If FIFO is full and not popped in the same cycle: entry dropped, overflow set.
  - Full with a simultaneous pop: push is accepted, count unchanged.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - con_valid = count != 0.
  - Pop when con_valid & con_ready.
  - First-word fall-through: a push into an empty FIFO makes con_valid high the next cycle.
  - con_data/con_mask hold stable while con_valid & !con_ready.
- Exit write (full or partial mask):
  - exit_code <= wdata with unmasked bytes 0; halted <= 1 the next cycle.
  - Further core writes are ignored.
  - FIFO keeps draining to the host.
- Status write: wmask[3] & wdata[29] clears overflow. A set and a clear cannot coincide (single bus).
- Status read:
  - rreq & addr == STATUS_ADDR gives rdata_sel = 1 and rdata valid the next cycle; otherwise rdata_sel = 0 and rdata = 0.
  - Layout: [31] halted, [30] timeout, [29] overflow, [28:16] 0, [15:0] FIFO count zero-extended.
  - Reads are allowed while frozen.
- Watchdog:
  - ticks increments each cycle while not frozen and saturates at all-ones.
  - When MAXTICKS != 0 and ticks == MAXTICKS-1 at an edge, timeout is set at that edge.
- An unmatched address produces no effect.
- Reset mid-FIFO or mid-halt clears everything immediately, including partially drained entries.

Optional Feature:
- MINIMAX_HOST_TSTAMP_EN defined:
  - Adds port con_tstamp out TICK_BITS.
  - Each FIFO entry also stores ticks at push time; con_tstamp is presented alongside con_data.
  - Status bits [28:16] are unchanged.
- Undefined: no port, no storage, no tick snapshot.

Decomposition:
- Package minimax_host_pkg:
  - default address constants,
  - status bit positions (HALT_BIT = 31, TIMEOUT_BIT = 30, OVF_BIT = 29, COUNT_LSB = 0, COUNT_W = 16),
  - typedef for the console entry struct {mask, data[, tstamp]}.
- Sub-module minimax_host_fifo: a parametrised synchronous FWFT FIFO exposing count, full, empty.
- Top level holds address decode, exit/watchdog/status registers and read mux.

Test Plan:
- Write wdata=32'hdeadbeef, wmask=4'hf to CONSOLE_ADDR with con_ready=1 -> next cycle con_valid=1, con_data=32'hdeadbeef, con_mask=4'hf; following cycle con_valid=0.
- Write 32'h12345678, wmask=4'b0011 -> con_data=32'h00005678, con_mask=4'b0011.
- Push 17 entries with con_ready=0, FIFO_DEPTH=16 -> count=16, overflow=1, 17th lost. Read STATUS -> 32'h20000010. Write STATUS wmask=4'h8, wdata=32'h20000000 -> overflow=0. Drain -> entries in order 0..15.
- When full, push while popping in the same cycle -> both accepted, overflow stays 0, count stays 16.
- Write 32'h0000002a to EXIT_ADDR -> halted=1, exit_code=32'h2a next cycle; a subsequent console write is ignored (count unchanged); STATUS read bit31=1.
- MAXTICKS=50, no writes -> timeout rises at exactly the 50th edge after reset release; assert reset low mid-run -> timeout, ticks and FIFO cleared asynchronously.
